// File: rtl/multicore_pkg.sv
// Shared types for the load/store path: store/load size encodings,
// the LSU state encoding and a helper giving the byte width of an access.
package multicore_pkg;

    localparam int DATA_SIZE = 32;

    // Store size: byte, halfword, word.
    typedef enum logic [1:0] {
        SOP_B = 2'd0,
        SOP_H = 2'd1,
        SOP_W = 2'd2
    } t_sop;

    // Load size and sign handling (the cache does the extension).
    typedef enum logic [2:0] {
        LDOP_B  = 3'd0,
        LDOP_H  = 3'd1,
        LDOP_W  = 3'd2,
        LDOP_BU = 3'd3,
        LDOP_HU = 3'd4
    } t_ldop;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Number of bytes touched by an access; stores use sop, loads use ldop.
    // Unknown encodings are treated as a full word so they fault conservatively.
    function automatic logic [2:0] access_bytes(input logic is_store, input t_sop sop,
                                                input t_ldop ldop);
        logic [2:0] bytes;
        bytes = 3'd4;
        if (is_store) begin
            case (sop)
                SOP_B:   bytes = 3'd1;
                SOP_H:   bytes = 3'd2;
                default: bytes = 3'd4;
            endcase
        end else begin
            case (ldop)
                LDOP_B, LDOP_BU: bytes = 3'd1;
                LDOP_H, LDOP_HU: bytes = 3'd2;
                default:         bytes = 3'd4;
            endcase
        end
        return bytes;
    endfunction

endpackage

// File: rtl/lsu_align_check.sv
// Alignment check for a single access: flags a halfword at an odd address
// or a word whose low two address bits are not zero. Bytes never fault.
module lsu_align_check
    import multicore_pkg::*;
(
    input  logic [1:0] addr_lsb_i,
    input  logic [2:0] size_bytes_i,
    output logic       misaligned_o
);

    // Pure function of the low address bits and the access width.
    always_comb begin
        misaligned_o = 1'b0;
        case (size_bytes_i)
            3'd2:    misaligned_o = addr_lsb_i[0];
            3'd4:    misaligned_o = |addr_lsb_i;
            default: misaligned_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit. Takes one op at a time from EX/MEM, traps
// misaligned accesses, issues aligned loads/stores to the data cache as a
// single request and returns exactly one writeback result per surviving op.
//
// Handshakes: EX side transfers when i_ex_valid & o_ex_ready & ~i_flush on a
// rising edge; cache side transfers when o_req & i_req_ready on a rising edge.
// o_req and its payload are held stable from assertion until that edge.
// The cache answers with a single-cycle i_data_valid, honoured only in WAIT.
module mem_stage_lsu
    import multicore_pkg::*;
#(
    parameter int ADDR_SIZE     = 32,
    parameter int REG_ADDR_BITS = 5
)
(
    input  logic                     i_aclk,
    input  logic                     i_areset_n,
    // EX/MEM side
    input  logic                     i_ex_valid,
    output logic                     o_ex_ready,
    input  logic                     i_ex_is_load,
    input  logic                     i_ex_is_store,
    input  logic [ADDR_SIZE-1:0]     i_ex_addr,
    input  logic [DATA_SIZE-1:0]     i_ex_store_data,
    input  t_sop                     i_ex_sop,
    input  t_ldop                    i_ex_ldop,
    input  logic [REG_ADDR_BITS-1:0] i_ex_rd,
    input  logic                     i_flush,
    // data cache side
    output logic                     o_req,
    output logic                     o_req_write,
    input  logic                     i_req_ready,
    output logic [ADDR_SIZE-1:0]     o_addr,
    output logic [DATA_SIZE-1:0]     o_store_data,
    output t_sop                     o_sop,
    output t_ldop                    o_ldop,
    input  logic                     i_data_valid,
    input  logic [DATA_SIZE-1:0]     i_data,
    // writeback side
    output logic                     o_wb_valid,
    output logic                     o_wb_we,
    output logic [REG_ADDR_BITS-1:0] o_wb_rd,
    output logic [DATA_SIZE-1:0]     o_wb_data,
    output logic                     o_exc_misaligned,
    output logic [ADDR_SIZE-1:0]     o_exc_addr,
    // debug
    output lsu_state_t               o_dbg_state
);

    lsu_state_t               state_q;
    logic                     is_load_q;
    logic                     is_store_q;
    logic [ADDR_SIZE-1:0]     addr_q;
    logic [DATA_SIZE-1:0]     store_data_q;
    t_sop                     sop_q;
    t_ldop                    ldop_q;
    logic [REG_ADDR_BITS-1:0] rd_q;
    logic                     req_q;
    logic                     flush_q;
    logic                     wb_valid_q;
    logic                     wb_we_q;
    logic [REG_ADDR_BITS-1:0] wb_rd_q;
    logic [DATA_SIZE-1:0]     wb_data_q;
    logic                     exc_q;
    logic [ADDR_SIZE-1:0]     exc_addr_q;

    logic                     accept;
    logic                     ex_is_mem;
    logic [2:0]               ex_size_bytes;
    logic                     ex_misaligned;
    logic                     handshake;

    assign accept        = i_ex_valid & (state_q == IDLE) & ~i_flush;
    assign ex_is_mem     = i_ex_is_load | i_ex_is_store;
    assign ex_size_bytes = access_bytes(i_ex_is_store, i_ex_sop, i_ex_ldop);
    assign handshake     = req_q & i_req_ready;

    lsu_align_check u_align_check (
        .addr_lsb_i   (i_ex_addr[1:0]),
        .size_bytes_i (ex_size_bytes),
        .misaligned_o (ex_misaligned)
    );

    // Main FSM: op register, cache request and writeback result all update here.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q      <= IDLE;
            is_load_q    <= 1'b0;
            is_store_q   <= 1'b0;
            addr_q       <= '0;
            store_data_q <= '0;
            sop_q        <= SOP_B;
            ldop_q       <= LDOP_B;
            rd_q         <= '0;
            req_q        <= 1'b0;
            flush_q      <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            exc_q        <= 1'b0;
            exc_addr_q   <= '0;
        end else begin
            // Result pulses last a single cycle unless re-armed below.
            wb_valid_q <= 1'b0;
            exc_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        is_load_q    <= i_ex_is_load;
                        is_store_q   <= i_ex_is_store;
                        addr_q       <= i_ex_addr;
                        store_data_q <= i_ex_store_data;
                        sop_q        <= i_ex_sop;
                        ldop_q       <= i_ex_ldop;
                        rd_q         <= i_ex_rd;
                        flush_q      <= 1'b0;
                        if (!ex_is_mem) begin
                            // ALU result passes straight through.
                            state_q    <= RESP;
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= (i_ex_rd != '0);
                            wb_rd_q    <= i_ex_rd;
                            wb_data_q  <= i_ex_addr;
                        end else if (ex_misaligned) begin
                            // Trap without touching the cache.
                            state_q    <= RESP;
                            wb_valid_q <= 1'b1;
                            exc_q      <= 1'b1;
                            exc_addr_q <= i_ex_addr;
                            wb_we_q    <= 1'b0;
                            wb_rd_q    <= i_ex_rd;
                        end else begin
                            state_q <= ISSUE;
                            req_q   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // Once the cache has taken the request it must complete,
                    // so a flush in the handshake cycle is not honoured.
                    if (handshake) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT;
                    end else if (i_flush) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (i_data_valid) begin
                        state_q <= RESP;
                        if (!(flush_q | i_flush)) begin
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= is_load_q & (rd_q != '0);
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= i_data;
                        end
                    end else if (i_flush) begin
                        flush_q <= 1'b1;
                    end
                end
                RESP: begin
                    flush_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_ex_ready       = (state_q == IDLE);
    assign o_req            = req_q;
    assign o_req_write      = is_store_q;
    assign o_addr           = addr_q;
    assign o_store_data     = store_data_q;
    assign o_sop            = sop_q;
    assign o_ldop           = ldop_q;
    // A flush during the result cycle still kills the writeback.
    assign o_wb_valid       = wb_valid_q & ~i_flush;
    assign o_exc_misaligned = exc_q & ~i_flush;
    assign o_wb_we          = wb_we_q;
    assign o_wb_rd          = wb_rd_q;
    assign o_wb_data        = wb_data_q;
    assign o_exc_addr       = exc_addr_q;
    assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: table of single ops with expected results,
// hand sequences for flush/stall/reset corners, a small data-cache model and
// a writeback scoreboard fed from an expected queue.
module tb_mem_stage_lsu;
    import multicore_pkg::*;

    localparam int AW  = 32;
    localparam int RW  = 5;
    localparam int DW  = DATA_SIZE;
    localparam int SBW = 72;   // {we, rd[5], exc, data[32], exc_addr[32], cmp_data}
    localparam int RQW = 70;   // {write, addr[32], sdata[32], sop[2], ldop[3]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          ex_valid = 0, ex_is_load = 0, ex_is_store = 0, flush = 0;
    logic [AW-1:0] ex_addr = '0;
    logic [DW-1:0] ex_sdata = '0;
    t_sop          ex_sop = SOP_B;
    t_ldop         ex_ldop = LDOP_B;
    logic [RW-1:0] ex_rd = '0;
    logic          req_ready = 0, data_valid = 0;
    logic [DW-1:0] cache_data = '0;

    logic          ex_ready, req, req_write, wb_valid, wb_we, exc_mis;
    logic [AW-1:0] addr, exc_addr;
    logic [DW-1:0] store_data, wb_data;
    t_sop          sop;
    t_ldop         ldop;
    logic [RW-1:0] wb_rd;
    lsu_state_t    dbg_state;

    mem_stage_lsu #(.ADDR_SIZE(AW), .REG_ADDR_BITS(RW)) dut (
        .i_aclk(clk), .i_areset_n(rst_n),
        .i_ex_valid(ex_valid), .o_ex_ready(ex_ready),
        .i_ex_is_load(ex_is_load), .i_ex_is_store(ex_is_store),
        .i_ex_addr(ex_addr), .i_ex_store_data(ex_sdata),
        .i_ex_sop(ex_sop), .i_ex_ldop(ex_ldop), .i_ex_rd(ex_rd),
        .i_flush(flush),
        .o_req(req), .o_req_write(req_write), .i_req_ready(req_ready),
        .o_addr(addr), .o_store_data(store_data), .o_sop(sop), .o_ldop(ldop),
        .i_data_valid(data_valid), .i_data(cache_data),
        .o_wb_valid(wb_valid), .o_wb_we(wb_we), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
        .o_exc_misaligned(exc_mis), .o_exc_addr(exc_addr),
        .o_dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    logic [SBW-1:0] exp_q[$];
    logic [RQW-1:0] req_q[$];

    // ---------------- writeback scoreboard ----------------
    int wb_pulses = 0;
    int last_wb_cyc = 0;
    logic [SBW-1:0] sb_e;
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            wb_pulses++;
            last_wb_cyc = cyc;
            if (exp_q.size() == 0) begin
                fail_now("wb_unexpected_pulse");
            end else begin
                sb_e = exp_q.pop_front();
                check("wb_we", wb_we, sb_e[71]);
                check("wb_rd", wb_rd, sb_e[70:66]);
                check("wb_exc", exc_mis, sb_e[65]);
                if (sb_e[65]) check("wb_exc_addr", exc_addr, sb_e[32:1]);
                if (sb_e[0]) check("wb_data", wb_data, sb_e[64:33]);
            end
        end
    end

    // ---------------- data cache model ----------------
    int rdy_dly = 0, dat_dly = 0;
    logic [DW-1:0] rdata = '0;
    int wait_cnt = 0, dcnt = 0;
    bit hs_pending = 0, resp_active = 0, stray_pulse = 0;
    int hs_count = 0, resp_count = 0;
    logic [RQW-1:0] cm_r;
    always @(negedge clk) begin
        req_ready  = 1'b0;
        data_valid = 1'b0;
        if (!rst_n) begin
            hs_pending = 0; resp_active = 0; wait_cnt = 0; stray_pulse = 0;
        end else begin
            if (stray_pulse) begin
                data_valid  = 1'b1;
                stray_pulse = 0;
            end
            if (hs_pending) begin
                hs_pending  = 0;
                resp_active = 1;
                dcnt        = dat_dly;
            end
            if (resp_active) begin
                if (dcnt == 0) begin
                    data_valid  = 1'b1;
                    cache_data  = rdata;
                    resp_active = 0;
                    resp_count++;
                end else begin
                    dcnt--;
                end
            end
            if (req) begin
                if (req_q.size() == 0) begin
                    fail_now("req_unexpected");
                end else begin
                    cm_r = req_q[0];
                    check("req_write", req_write, cm_r[69]);
                    check("req_addr", addr, cm_r[68:37]);
                    check("req_sdata", store_data, cm_r[36:5]);
                    check("req_sop", sop, cm_r[4:3]);
                    check("req_ldop", ldop, cm_r[2:0]);
                end
                if (wait_cnt >= rdy_dly) begin
                    req_ready  = 1'b1;
                    hs_pending = 1;
                    wait_cnt   = 0;
                    hs_count++;
                    if (req_q.size() > 0) void'(req_q.pop_front());
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- vectors and drivers ----------------
    typedef struct {
        logic          ld;
        logic          st;
        logic [AW-1:0] addr;
        logic [DW-1:0] sdata;
        t_sop          sop;
        t_ldop         ldop;
        logic [RW-1:0] rd;
        int            rdy;
        int            dly;
        logic [DW-1:0] rdata;
        logic          exp_req;
        logic          exp_we;
        logic          exp_exc;
    } vec_t;

    function automatic vec_t mk(input logic ld, input logic st, input logic [AW-1:0] a,
                                input logic [DW-1:0] sd, input t_sop so, input t_ldop lo,
                                input logic [RW-1:0] rd, input int rdy, input int dly,
                                input logic [DW-1:0] rdat, input logic e_req,
                                input logic e_we, input logic e_exc);
        vec_t v;
        v.ld = ld; v.st = st; v.addr = a; v.sdata = sd; v.sop = so; v.ldop = lo;
        v.rd = rd; v.rdy = rdy; v.dly = dly; v.rdata = rdat;
        v.exp_req = e_req; v.exp_we = e_we; v.exp_exc = e_exc;
        return v;
    endfunction

    int acc_cyc = 0;

    // Drive one op, wait for it to be accepted, record expectations.
    task automatic do_op(input vec_t v, input bit push_wb);
        int t;
        logic [DW-1:0] d;
        logic cmp;
        rdy_dly = v.rdy; dat_dly = v.dly; rdata = v.rdata;
        @(negedge clk);
        ex_is_load = v.ld; ex_is_store = v.st; ex_addr = v.addr; ex_sdata = v.sdata;
        ex_sop = v.sop; ex_ldop = v.ldop; ex_rd = v.rd; ex_valid = 1'b1;
        t = 0;
        while (!ex_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ex_ready) fail_now("ex_ready_timeout");
        acc_cyc = cyc;
        d   = (v.ld | v.st) ? v.rdata : v.addr;
        cmp = !v.exp_exc && (v.ld || !(v.ld | v.st));
        if (v.exp_req) req_q.push_back({v.st, v.addr, v.sdata, v.sop, v.ldop});
        if (push_wb) exp_q.push_back({v.exp_we, v.rd, v.exp_exc, d, v.addr, cmp});
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((!ex_ready || exp_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ex_ready || exp_q.size() != 0) fail_now("wait_idle_timeout");
    endtask

    task automatic wait_state(input lsu_state_t s);
        int t;
        t = 0;
        while (dbg_state != s && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (dbg_state != s) fail_now("wait_state_timeout");
    endtask

    vec_t vecs[12];
    vec_t hv;
    int hs0, wb0, rs0;

    initial begin
        $timeformat(-9, 0, "ns", 6);
        vecs[0]  = mk(1, 0, 32'h100, 32'h0,        SOP_W, LDOP_W,  5, 0, 2, 32'hDEADBEEF, 1, 1, 0);
        vecs[1]  = mk(0, 1, 32'h203, 32'hBEEF,     SOP_H, LDOP_W,  5, 0, 0, 32'h0,        0, 0, 1);
        vecs[2]  = mk(0, 1, 32'h40,  32'h12345678, SOP_W, LDOP_W,  6, 4, 0, 32'h0,        1, 0, 0);
        vecs[3]  = mk(0, 0, 32'h55,  32'h0,        SOP_B, LDOP_B,  0, 0, 0, 32'h0,        0, 0, 0);
        vecs[4]  = mk(0, 0, 32'hA5A5,32'h0,        SOP_B, LDOP_B,  7, 0, 0, 32'h0,        0, 1, 0);
        vecs[5]  = mk(1, 0, 32'h102, 32'h0,        SOP_B, LDOP_H,  3, 1, 0, 32'hFFFF8001, 1, 1, 0);
        vecs[6]  = mk(1, 0, 32'h106, 32'h0,        SOP_B, LDOP_W,  1, 0, 0, 32'h0,        0, 0, 1);
        vecs[7]  = mk(1, 0, 32'h7,   32'h0,        SOP_B, LDOP_B,  2, 0, 1, 32'h12,       1, 1, 0);
        vecs[8]  = mk(1, 0, 32'h8,   32'h0,        SOP_B, LDOP_W,  0, 0, 0, 32'h77,       1, 0, 0);
        vecs[9]  = mk(1, 0, 32'h31,  32'h0,        SOP_B, LDOP_HU, 4, 0, 0, 32'h0,        0, 0, 1);
        vecs[10] = mk(0, 1, 32'h33,  32'hAB,       SOP_B, LDOP_B,  9, 2, 0, 32'h0,        1, 0, 0);
        vecs[11] = mk(0, 1, 32'h2,   32'h55667788, SOP_W, LDOP_B, 10, 0, 0, 32'h0,        0, 0, 1);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ex_ready", ex_ready, 1);
        check("rst_req", req, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_exc", exc_mis, 0);
        check("rst_addr", addr, 0);
        check("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;

        // Table of single ops
        for (int i = 0; i < 12; i++) begin
            hs0 = hs_count;
            do_op(vecs[i], 1);
            wait_idle();
            check($sformatf("vec%0d_req_count", i), hs_count - hs0, {31'd0, vecs[i].exp_req});
        end

        // Latency: minimal load is 3 cycles, ALU is 1 cycle
        do_op(mk(1, 0, 32'h80, 0, SOP_B, LDOP_W, 9, 0, 0, 32'hCAFEF00D, 1, 1, 0), 1);
        wait_idle();
        check("load_latency", last_wb_cyc - acc_cyc, 3);
        do_op(mk(0, 0, 32'h1234, 0, SOP_B, LDOP_B, 11, 0, 0, 0, 0, 1, 0), 1);
        wait_idle();
        check("alu_latency", last_wb_cyc - acc_cyc, 1);

        // Store with slow cache: request held, EX side stalled
        do_op(mk(0, 1, 32'h40, 32'h0BADCAFE, SOP_W, LDOP_B, 3, 4, 0, 0, 1, 0, 0), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_req_held", req, 1);
            check("stall_ex_ready", ex_ready, 0);
        end
        wait_idle();

        // Flush in ISSUE before the cache is ready: request withdrawn
        wb0 = wb_pulses;
        do_op(mk(1, 0, 32'h10, 0, SOP_B, LDOP_B, 2, 10, 0, 0, 1, 1, 0), 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("issue_flush_req", req, 0);
        check("issue_flush_ready", ex_ready, 1);
        req_q.delete();
        repeat (4) @(negedge clk);
        check("issue_flush_no_wb", wb_pulses - wb0, 0);

        // Flush coincident with handshake: request committed, result returned
        hs0 = hs_count;
        do_op(mk(1, 0, 32'h60, 0, SOP_B, LDOP_W, 6, 0, 1, 32'h600D600D, 1, 1, 0), 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_idle();
        check("hs_flush_req_count", hs_count - hs0, 1);

        // Flush in WAIT: access completes, writeback suppressed
        wb0 = wb_pulses; rs0 = resp_count; hs0 = hs_count;
        do_op(mk(1, 0, 32'h20, 0, SOP_B, LDOP_W, 4, 0, 3, 32'h11112222, 1, 1, 0), 0);
        wait_state(WAIT);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        check("wait_flush_hs", hs_count - hs0, 1);
        check("wait_flush_resp", resp_count - rs0, 1);
        check("wait_flush_no_wb", wb_pulses - wb0, 0);

        // Flush in IDLE blocks accept
        wb0 = wb_pulses;
        @(negedge clk);
        ex_is_load = 0; ex_is_store = 0; ex_addr = 32'h99; ex_rd = 5'd3;
        ex_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; flush = 1'b0;
        check("idle_flush_state", dbg_state, IDLE);
        repeat (2) @(negedge clk);
        check("idle_flush_no_wb", wb_pulses - wb0, 0);

        // Stray data_valid while idle is ignored
        wb0 = wb_pulses;
        stray_pulse = 1;
        repeat (3) @(negedge clk);
        check("stray_state", dbg_state, IDLE);
        check("stray_no_wb", wb_pulses - wb0, 0);

        // Back-to-back ALU ops, rd=0 then rd=7
        wb0 = wb_pulses;
        do_op(mk(0, 0, 32'h1111, 0, SOP_B, LDOP_B, 0, 0, 0, 0, 0, 0, 0), 1);
        do_op(mk(0, 0, 32'h2222, 0, SOP_B, LDOP_B, 7, 0, 0, 0, 0, 1, 0), 1);
        wait_idle();
        check("b2b_pulses", wb_pulses - wb0, 2);

        // Random ALU passthrough ops
        for (int k = 0; k < 6; k++) begin
            hv = mk(0, 0, $urandom, 0, SOP_B, LDOP_B, 5'($urandom_range(0, 31)), 0, 0, 0, 0, 0, 0);
            hv.exp_we = (hv.rd != 0);
            do_op(hv, 1);
        end
        wait_idle();

        // Reset asserted mid-WAIT
        do_op(mk(1, 0, 32'h300, 0, SOP_B, LDOP_W, 8, 0, 20, 32'h33, 1, 1, 0), 0);
        wait_state(WAIT);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", ex_ready, 1);
        check("mid_rst_req", req, 0);
        check("mid_rst_wb_valid", wb_valid, 0);
        check("mid_rst_wb_data", wb_data, 0);
        check("mid_rst_wb_rd", wb_rd, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_state", dbg_state, IDLE);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_ready", ex_ready, 1);

        check("exp_q_drained", exp_q.size(), 0);
        check("req_q_drained", req_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
